// File: rtl/hazard_pkg.sv
// Shared types for the hazard/scoreboard block: forward-select encoding and register-0 index.
// Pure declarations: no logic, no latency.
// No handshakes.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/mc_unit_timer.sv
// Busy timer for one multi-cycle unit: counts down the issued latency and remembers the owner register.
// Latency: busy the edge after start, release pulse is combinational in the unit's last busy cycle.
// No backpressure: start is only raised by the top when the unit is idle.
module mc_unit_timer #(
    parameter int AW = 5,
    parameter int LW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] lat,
    input  logic [AW-1:0] dest,
    input  logic          done,
    output logic          busy,
    output logic [AW-1:0] owner,
    output logic          rel_vld
);

    logic [LW-1:0] timer_q;

    // A zero latency is treated like one so the unit can never wrap and hang.
    assign rel_vld = busy && (done || timer_q <= LW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            busy    <= 1'b0;
            owner   <= '0;
        end else if (start) begin
            timer_q <= lat;
            busy    <= 1'b1;
            owner   <= dest;
        end else if (rel_vld) begin
            timer_q <= '0;
            busy    <= 1'b0;
        end else if (busy) begin
            timer_q <= timer_q - LW'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: E/M/W forwarding, load-use/branch stalls, register scoreboard for multi-cycle units.
// Latency: all stall/flush/forward outputs combinational; scoreboard and unit state update on the next edge.
// Backpressure: stall holds F/D and bubbles E; flush_pipe overrides stall and blocks new multi-cycle issue.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NUNIT = 2,
    parameter int UW    = 1,
    parameter int LW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs_d,
    input  logic [AW-1:0]    rt_d,
    input  logic [AW-1:0]    rs_e,
    input  logic [AW-1:0]    rt_e,
    input  logic [AW-1:0]    wreg_e,
    input  logic [AW-1:0]    wreg_m,
    input  logic [AW-1:0]    wreg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memtoreg_m,
    input  logic             ovf_m,
    input  logic             branch_d,
    input  logic             mc_issue_d,
    input  logic [UW-1:0]    mc_unit_d,
    input  logic [AW-1:0]    mc_dest_d,
    input  logic [LW-1:0]    mc_lat_d,
    input  logic [NUNIT-1:0] mc_done,
    input  logic             flush_pipe,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             mc_accept,
    output logic [NUNIT-1:0] unit_busy,
    output logic [NREG-1:0]  pending
);

    localparam logic [AW-1:0] R0 = AW'(REG_ZERO);

    function automatic logic reg_hit(input logic en, input logic [AW-1:0] src, input logic [AW-1:0] dst);
        return en && (src != R0) && (src == dst);
    endfunction

    fwd_sel_t fwd_a_sel, fwd_b_sel;
    logic     load_use, br_haz, sb_raw, sb_waw, struct_haz, stall;

    logic [NREG-1:0]           pending_q, pending_nxt;
    logic [NUNIT-1:0]          rel_vld;
    logic [NUNIT-1:0][AW-1:0]  owner;

    // An overflowing M-stage result is never committed, so W (older) is the right source.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (reg_hit(regwrite_m, rs_e, wreg_m) && !ovf_m) fwd_a_sel = FWD_M;
        else if (reg_hit(regwrite_w, rs_e, wreg_w))      fwd_a_sel = FWD_W;
        if (reg_hit(regwrite_m, rt_e, wreg_m) && !ovf_m) fwd_b_sel = FWD_M;
        else if (reg_hit(regwrite_w, rt_e, wreg_w))      fwd_b_sel = FWD_W;
    end

    assign fwd_a_e = fwd_a_sel;
    assign fwd_b_e = fwd_b_sel;
    assign fwd_a_d = reg_hit(regwrite_m, rs_d, wreg_m);
    assign fwd_b_d = reg_hit(regwrite_m, rt_d, wreg_m);

    assign load_use   = memtoreg_e && (wreg_e != R0) && ((rs_d == wreg_e) || (rt_d == wreg_e));
    assign br_haz     = branch_d && (reg_hit(regwrite_e, rs_d, wreg_e) || reg_hit(regwrite_e, rt_d, wreg_e) ||
                                     reg_hit(memtoreg_m, rs_d, wreg_m) || reg_hit(memtoreg_m, rt_d, wreg_m));
    assign sb_raw     = pending_q[rs_d] || pending_q[rt_d];
    assign sb_waw     = mc_issue_d && pending_q[mc_dest_d];
    assign struct_haz = mc_issue_d && unit_busy[mc_unit_d];
    assign stall      = load_use || br_haz || sb_raw || sb_waw || struct_haz;

    assign stall_f   = !flush_pipe && stall;
    assign stall_d   = !flush_pipe && stall;
    assign flush_e   = flush_pipe || stall;
    assign mc_accept = mc_issue_d && !stall && !flush_pipe;

    for (genvar u = 0; u < NUNIT; u++) begin : g_unit
        mc_unit_timer #(
            .AW (AW),
            .LW (LW)
        ) u_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (mc_accept && (mc_unit_d == UW'(u))),
            .lat     (mc_lat_d),
            .dest    (mc_dest_d),
            .done    (mc_done[u]),
            .busy    (unit_busy[u]),
            .owner   (owner[u]),
            .rel_vld (rel_vld[u])
        );
    end

    // Releases are applied first so a same-edge accept of the same register keeps it pending.
    always_comb begin
        pending_nxt = pending_q;
        for (int u = 0; u < NUNIT; u++) begin
            if (rel_vld[u]) pending_nxt[owner[u]] = 1'b0;
        end
        if (mc_accept && (mc_dest_d != R0)) pending_nxt[mc_dest_d] = 1'b1;
        pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_nxt;
    end

    assign pending = pending_q;

endmodule
